// File: rtl/micro_sequencer_if.sv
// Control-ROM, flag handshake and status bundle between micro_sequencer and its datapath.
// master is the sequencer side; slave is the ROM/datapath/host side.
interface micro_sequencer_if #(
   parameter int AW = 8
);
   logic          start;
   logic          abort;
   logic [1:0]    seq_op;
   logic [2:0]    cond_sel;
   logic [AW-1:0] target;
   logic [3:0]    alu_flags;
   logic          flags_valid;
   logic [AW-1:0] instr_addr;
   logic          instr_valid;
   logic          busy;
   logic          done;
   logic          error;

   modport master (
      input  start, abort, seq_op, cond_sel, target, alu_flags, flags_valid,
      output instr_addr, instr_valid, busy, done, error
   );

   modport slave (
      output start, abort, seq_op, cond_sel, target, alu_flags, flags_valid,
      input  instr_addr, instr_valid, busy, done, error
   );
endinterface

// File: rtl/micro_sequencer.sv
// Programmable instruction-address sequencer: walks a synchronous control ROM,
// branching on ALU flags with a flag-valid handshake and a bounded wait.
module micro_sequencer #(
   parameter int            AW         = 8,
   parameter logic [AW-1:0] START_ADDR = '0,
   parameter int            WAIT_MAX   = 15
) (
   input  logic               clk,
   input  logic               reset,
   micro_sequencer_if.master  bus
);
   localparam int            CW        = $clog2(WAIT_MAX + 1);
   localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_MAX - 1);

   localparam logic [1:0] OP_NEXT   = 2'b00;
   localparam logic [1:0] OP_JUMP   = 2'b01;
   localparam logic [1:0] OP_BRANCH = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_WAIT,
      S_DONE
   } state_t;

   state_t        state_reg, state_next;
   logic [AW-1:0] addr_reg, addr_next;
   logic [AW-1:0] target_reg, target_next;
   logic [2:0]    cond_reg, cond_next;
   logic [CW-1:0] wait_cnt_reg, wait_cnt_next;
   logic          error_reg, error_next;
   logic          taken;

   // Branch decision uses the condition latched in EXEC; the ROM word has moved on by now.
   assign taken = bus.alu_flags[cond_reg[1:0]] ^ cond_reg[2];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= S_IDLE;
         addr_reg     <= '0;
         target_reg   <= '0;
         cond_reg     <= '0;
         wait_cnt_reg <= '0;
         error_reg    <= 1'b0;
      end else begin
         state_reg    <= state_next;
         addr_reg     <= addr_next;
         target_reg   <= target_next;
         cond_reg     <= cond_next;
         wait_cnt_reg <= wait_cnt_next;
         error_reg    <= error_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      addr_next     = addr_reg;
      target_next   = target_reg;
      cond_next     = cond_reg;
      wait_cnt_next = wait_cnt_reg;
      error_next    = error_reg;

      unique case (state_reg)
         S_IDLE: begin
            if (bus.start) begin
               addr_next  = START_ADDR;
               error_next = 1'b0;
               state_next = S_FETCH;
            end
         end
         S_FETCH: state_next = S_EXEC;
         S_EXEC: begin
            case (bus.seq_op)
               OP_NEXT: begin
                  addr_next  = addr_reg + 1'b1;
                  state_next = S_FETCH;
               end
               OP_JUMP: begin
                  addr_next  = bus.target;
                  state_next = S_FETCH;
               end
               OP_BRANCH: begin
                  wait_cnt_next = '0;
                  cond_next     = bus.cond_sel;
                  target_next   = bus.target;
                  state_next    = S_WAIT;
               end
               default: state_next = S_DONE;
            endcase
         end
         S_WAIT: begin
            if (bus.flags_valid) begin
               addr_next  = taken ? target_reg : addr_reg + 1'b1;
               state_next = S_FETCH;
            end else if (wait_cnt_reg == WAIT_LAST) begin
               error_next = 1'b1;
               state_next = S_IDLE;
            end else begin
               wait_cnt_next = wait_cnt_reg + 1'b1;
            end
         end
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase

      // Abort overrides everything, leaving address and error untouched.
      if (bus.abort) begin
         state_next    = S_IDLE;
         addr_next     = addr_reg;
         target_next   = target_reg;
         cond_next     = cond_reg;
         wait_cnt_next = wait_cnt_reg;
         error_next    = error_reg;
      end
   end

   assign bus.instr_addr  = addr_reg;
   assign bus.instr_valid = (state_reg == S_EXEC);
   assign bus.busy        = (state_reg != S_IDLE);
   assign bus.done        = (state_reg == S_DONE);
   assign bus.error       = error_reg;
endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: a per-cycle vector table plus hand-written
// sequences for branch loops, address wrap, flag timeout, abort and reset.
module tb_micro_sequencer;
   logic clk;
   logic reset;
   int   tests = 0;
   int   fails = 0;

   micro_sequencer_if #(.AW(8)) bus ();

   micro_sequencer #(
      .AW(8),
      .START_ADDR(8'h00),
      .WAIT_MAX(15)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Control ROM with one cycle of read latency.
   logic [1:0] rom_op  [256];
   logic [2:0] rom_cs  [256];
   logic [7:0] rom_tgt [256];
   logic [1:0] rom_q_op;
   logic [2:0] rom_q_cs;
   logic [7:0] rom_q_tgt;

   always @(posedge clk) begin
      rom_q_op  <= rom_op[bus.instr_addr];
      rom_q_cs  <= rom_cs[bus.instr_addr];
      rom_q_tgt <= rom_tgt[bus.instr_addr];
   end

   assign bus.seq_op   = rom_q_op;
   assign bus.cond_sel = rom_q_cs;
   assign bus.target   = rom_q_tgt;

   typedef struct packed {
      logic       start;
      logic       abort;
      logic       fv;
      logic [3:0] flags;
      logic [7:0] e_addr;
      logic       e_valid;
      logic       e_busy;
      logic       e_done;
      logic       e_err;
   } vec_t;

   vec_t       vecs [12];
   logic [7:0] trace [$];
   logic [7:0] exp_trace [$];
   logic [3:0] flag_q [$];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) begin
         rom_op[i]  = 2'b11;
         rom_cs[i]  = 3'd0;
         rom_tgt[i] = 8'h00;
      end
   endtask

   task automatic set_rom(input logic [7:0] a, input logic [1:0] op, input logic [2:0] cs,
                          input logic [7:0] tgt);
      rom_op[a]  = op;
      rom_cs[a]  = cs;
      rom_tgt[a] = tgt;
   endtask

   task automatic chk_outputs(input string name, input logic [7:0] addr, input logic valid,
                              input logic busy, input logic done, input logic err);
      chk({name, " addr"},  32'(bus.instr_addr),  32'(addr));
      chk({name, " valid"}, 32'(bus.instr_valid), 32'(valid));
      chk({name, " busy"},  32'(bus.busy),        32'(busy));
      chk({name, " done"},  32'(bus.done),        32'(done));
      chk({name, " error"}, 32'(bus.error),       32'(err));
   endtask

   // Start a program from IDLE and run it to completion, answering each BRANCH
   // with the next entry of flag_q after fl_delay silent WAIT cycles.
   task automatic run_prog(input string name, input int budget, input int fl_delay,
                           output int cycles, output int dones, output int waits);
      bit br_prev = 0;
      bit in_wait = 0;
      int wc      = 0;
      trace.delete();
      cycles = 0;
      dones  = 0;
      waits  = 0;
      bus.start = 1'b1;
      for (int c = 1; c <= budget; c++) begin
         @(posedge clk); #1;
         bus.start       = 1'b0;
         bus.flags_valid = 1'b0;
         cycles = c;
         if (bus.done) dones++;
         if (!bus.busy) break;
         if (br_prev) begin
            in_wait = 1;
            wc      = 0;
         end
         br_prev = 0;
         if (bus.instr_valid) begin
            trace.push_back(bus.instr_addr);
            br_prev = (rom_op[bus.instr_addr] == 2'b10);
            in_wait = 0;
         end else if (in_wait) begin
            waits++;
            if (wc == fl_delay && flag_q.size() != 0) begin
               bus.flags_valid = 1'b1;
               bus.alu_flags   = flag_q.pop_front();
               in_wait         = 0;
            end else begin
               wc++;
            end
         end
      end
      bus.flags_valid = 1'b0;
      chk({name, " finished within budget"}, 32'(bus.busy), 32'd0);
   endtask

   task automatic check_trace(input string name);
      chk({name, " trace length"}, 32'(trace.size()), 32'(exp_trace.size()));
      for (int i = 0; i < exp_trace.size(); i++) begin
         if (i < trace.size())
            chk($sformatf("%s trace[%0d]", name, i), 32'(trace[i]), 32'(exp_trace[i]));
      end
   endtask

   initial begin
      int cyc, dn, wt;
      reset           = 1'b1;
      bus.start       = 1'b0;
      bus.abort       = 1'b0;
      bus.flags_valid = 1'b0;
      bus.alu_flags   = 4'h0;
      clear_rom();

      // Straight-line program plus start/abort corner cases, one record per clock.
      set_rom(8'h00, 2'b00, 3'd0, 8'h00);
      set_rom(8'h01, 2'b00, 3'd0, 8'h00);
      set_rom(8'h02, 2'b11, 3'd0, 8'h00);
      //              start abort fv    flags  addr   vld   busy  done  err
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 1'b1, 4'hF, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 4'h0, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 4'h0, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 4'h0, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 4'h0, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 4'h0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 1'b1, 1'b0, 4'h0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};

      repeat (2) @(posedge clk);
      #1;
      chk_outputs("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;

      for (int i = 0; i < 12; i++) begin
         bus.start       = vecs[i].start;
         bus.abort       = vecs[i].abort;
         bus.flags_valid = vecs[i].fv;
         bus.alu_flags   = vecs[i].flags;
         @(posedge clk); #1;
         chk_outputs($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_valid,
                     vecs[i].e_busy, vecs[i].e_done, vecs[i].e_err);
         $display("[TB] vec%0d addr=%02h valid=%0b busy=%0b done=%0b", i,
                  bus.instr_addr, bus.instr_valid, bus.busy, bus.done);
      end
      bus.start       = 1'b0;
      bus.abort       = 1'b0;
      bus.flags_valid = 1'b0;

      // Branch loop: inverted test of flag 0, taken twice, then falls through.
      clear_rom();
      set_rom(8'h00, 2'b01, 3'd0, 8'h02);
      set_rom(8'h02, 2'b00, 3'd0, 8'h00);
      set_rom(8'h03, 2'b10, 3'b100, 8'h02);
      set_rom(8'h04, 2'b11, 3'd0, 8'h00);
      flag_q    = '{4'b1110, 4'b1110, 4'b0001};
      exp_trace = '{8'h00, 8'h02, 8'h03, 8'h02, 8'h03, 8'h02, 8'h03, 8'h04};
      run_prog("loop", 100, 1, cyc, dn, wt);
      check_trace("loop");
      chk("loop cycles to idle", 32'(cyc), 32'd24);
      chk("loop wait cycles", 32'(wt), 32'd6);
      chk("loop done pulses", 32'(dn), 32'd1);
      $display("[TB] loop cycles=%0d waits=%0d dones=%0d", cyc, wt, dn);

      // Address wrap: branch at 0 on flag 1 jumps to FE, then NEXT runs past FF.
      clear_rom();
      set_rom(8'h00, 2'b10, 3'b001, 8'hFE);
      set_rom(8'hFE, 2'b00, 3'd0, 8'h00);
      set_rom(8'hFF, 2'b00, 3'd0, 8'h00);
      set_rom(8'h01, 2'b11, 3'd0, 8'h00);
      flag_q    = '{4'b0010, 4'b1101};
      exp_trace = '{8'h00, 8'hFE, 8'hFF, 8'h00, 8'h01};
      run_prog("wrap", 100, 0, cyc, dn, wt);
      check_trace("wrap");
      chk("wrap cycles to idle", 32'(cyc), 32'd14);
      chk("wrap done pulses", 32'(dn), 32'd1);
      $display("[TB] wrap cycles=%0d waits=%0d dones=%0d", cyc, wt, dn);

      // Flag timeout: no flags_valid ever arrives.
      clear_rom();
      set_rom(8'h00, 2'b10, 3'b010, 8'h05);
      flag_q.delete();
      exp_trace = '{8'h00};
      run_prog("timeout", 100, 0, cyc, dn, wt);
      check_trace("timeout");
      chk("timeout wait cycles", 32'(wt), 32'd15);
      chk("timeout cycles to idle", 32'(cyc), 32'd18);
      chk("timeout done pulses", 32'(dn), 32'd0);
      chk("timeout error", 32'(bus.error), 32'd1);
      chk("timeout addr holds", 32'(bus.instr_addr), 32'h00);
      $display("[TB] timeout cycles=%0d waits=%0d error=%0b", cyc, wt, bus.error);

      // A fresh start clears the sticky error.
      clear_rom();
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("restart error cleared", 32'(bus.error), 32'd0);
      chk("restart busy", 32'(bus.busy), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      chk("restart halt back to idle", 32'(bus.busy), 32'd0);
      $display("[TB] restart error=%0b busy=%0b", bus.error, bus.busy);

      // Abort in WAIT_FLAGS wins over a simultaneous flags_valid.
      set_rom(8'h00, 2'b10, 3'b000, 8'h40);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("abort pre busy", 32'(bus.busy), 32'd1);
      bus.abort       = 1'b1;
      bus.flags_valid = 1'b1;
      bus.alu_flags   = 4'hF;
      @(posedge clk); #1;
      bus.abort       = 1'b0;
      chk_outputs("abort wait", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      bus.flags_valid = 1'b0;
      chk("abort stays idle", 32'(bus.busy), 32'd0);
      $display("[TB] abort-in-wait addr=%02h busy=%0b", bus.instr_addr, bus.busy);

      // Asynchronous reset mid-loop clears outputs before the next edge.
      clear_rom();
      set_rom(8'h00, 2'b01, 3'd0, 8'h02);
      set_rom(8'h02, 2'b00, 3'd0, 8'h00);
      set_rom(8'h03, 2'b10, 3'b100, 8'h02);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("pre-reset addr", 32'(bus.instr_addr), 32'h03);
      chk("pre-reset busy", 32'(bus.busy), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk_outputs("async reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      $display("[TB] async reset addr=%02h busy=%0b", bus.instr_addr, bus.busy);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      chk("post-reset idle", 32'(bus.busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
